// File: rtl/temp_bcd_conv.sv
// Sequential double-dabble converter: signed temperature word to packed BCD,
// sign flag and leading-zero blank mask for the 7-segment display path.
module temp_bcd_conv #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic [WIDTH-1:0]      iBIN,
  output logic                  oBUSY,
  output logic                  oVALID,
  output logic                  oNEG,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic [DIGITS-1:0]     oBLANK
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              neg_q, neg_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  function automatic logic [BW-1:0] add3_f(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // A digit is blanked only when it and every more-significant digit are zero.
  function automatic logic [DIGITS-1:0] blank_f(input logic [BW-1:0] s);
    logic [DIGITS-1:0] b;
    logic              all_zero;
    b        = {DIGITS{1'b0}};
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (s[4*i +: 4] == 4'd0);
      b[i]     = all_zero;
    end
    return b;
  endfunction

  // State and datapath registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      bin_q     <= {WIDTH{1'b0}};
      mag_q     <= {WIDTH{1'b0}};
      scratch_q <= {BW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      neg_q     <= 1'b0;
      bcd_q     <= {BW{1'b0}};
      blank_q   <= BLANK_RST;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    neg_d     = neg_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          bin_d   = iBIN;
          busy_d  = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // Unsigned magnitude so the most negative input negates cleanly.
        sign_d    = bin_q[WIDTH-1];
        mag_d     = bin_q[WIDTH-1] ? (~bin_q + {{(WIDTH-1){1'b0}}, 1'b1}) : bin_q;
        scratch_d = {BW{1'b0}};
        cnt_d     = {CW{1'b0}};
        state_d   = SHIFT;
      end
      SHIFT: begin
        scratch_d = (add3_f(scratch_q) << 1'b1) | BW'(mag_q[WIDTH-1]);
        mag_d     = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        bcd_d   = scratch_q;
        blank_d = blank_f(scratch_q);
        neg_d   = sign_q & (scratch_q != {BW{1'b0}});
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign oBUSY  = busy_q;
  assign oVALID = valid_q;
  assign oNEG   = neg_q;
  assign oBCD   = bcd_q;
  assign oBLANK = blank_q;

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Scoreboard bench for temp_bcd_conv: expected results are queued at the
// accepting edge and compared whenever oVALID is seen.
module tb_temp_bcd_conv;

  localparam int W = 10;
  localparam int D = 4;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic             iSTART;
  logic [W-1:0]     iBIN;
  logic             oBUSY;
  logic             oVALID;
  logic             oNEG;
  logic [4*D-1:0]   oBCD;
  logic [D-1:0]     oBLANK;

  typedef struct packed {
    logic [4*D-1:0] bcd;
    logic [D-1:0]   blank;
    logic           neg;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;

  temp_bcd_conv #(.WIDTH(W), .DIGITS(D)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .iBIN   (iBIN),
    .oBUSY  (oBUSY),
    .oVALID (oVALID),
    .oNEG   (oNEG),
    .oBCD   (oBCD),
    .oBLANK (oBLANK)
  );

  always #5 iCLK = ~iCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model using decimal arithmetic.
  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    int   s;
    int   m;
    bit   all_zero;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    e.bcd = '0;
    for (int i = 0; i < D; i++) e.bcd[4*i +: 4] = 4'((m / (10 ** i)) % 10);
    e.blank  = '0;
    all_zero = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      all_zero   = all_zero && (e.bcd[4*i +: 4] == 4'd0);
      e.blank[i] = all_zero;
    end
    e.neg = (m != 0) && (s < 0);
    return e;
  endfunction

  always @(negedge iCLK) begin
    if (oVALID === 1'b1) begin
      exp_t e;
      valid_cnt++;
      check_eq("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("bcd", oBCD, e.bcd);
        check_eq("blank", oBLANK, e.blank);
        check_eq("neg", oNEG, e.neg);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_bcd"}, oBCD, 16'h0000);
    check_eq({tag, "_blank"}, oBLANK, 4'b1110);
    check_eq({tag, "_neg"}, oNEG, 1'b0);
    check_eq({tag, "_busy"}, oBUSY, 1'b0);
    check_eq({tag, "_valid"}, oVALID, 1'b0);
  endtask

  // One conversion; inject=1 pulses a stray start during SHIFT and DONE.
  task automatic conv(input logic [W-1:0] v, input bit inject);
    int n;
    @(posedge iCLK); #1;
    iBIN   = v;
    iSTART = 1'b1;
    @(posedge iCLK);
    sb_q.push_back(model(v));
    #1;
    iSTART = 1'b0;
    iBIN   = W'($urandom);
    n = 0;
    do begin
      @(posedge iCLK); #1;
      n++;
      if (inject && (n == 4 || n == 11)) begin
        iSTART = 1'b1;
        iBIN   = 10'd99;
      end else begin
        iSTART = 1'b0;
      end
    end while (oVALID !== 1'b1 && n < 20);
    check_eq("latency", n, 12);
    @(posedge iCLK); #1;
    check_eq("valid_pulse", oVALID, 1'b0);
    check_eq("busy_after", oBUSY, 1'b0);
  endtask

  initial begin
    int vc;
    iRST   = 1'b1;
    iSTART = 1'b0;
    iBIN   = '0;
    #12;
    check_reset_outputs("por");
    @(posedge iCLK); #1;
    iRST = 1'b0;

    conv(10'd0,   1'b0);
    conv(10'd345, 1'b0);
    conv(10'd511, 1'b0);

    @(posedge iCLK); #3;
    iRST = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge iCLK); #1;
    iRST = 1'b0;

    conv(10'h3D8, 1'b0);
    conv(10'h200, 1'b0);
    conv(10'h3FF, 1'b0);

    vc = valid_cnt;
    conv(10'd25, 1'b1);
    repeat (15) @(posedge iCLK);
    check_eq("single_valid", valid_cnt - vc, 1);

    @(posedge iCLK); #1;
    iBIN   = 10'd345;
    iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    vc = valid_cnt;
    repeat (4) @(posedge iCLK);
    #3;
    iRST = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    repeat (20) @(posedge iCLK);
    check_eq("abort_no_valid", valid_cnt - vc, 0);

    conv(10'd7, 1'b0);

    repeat (3) @(posedge iCLK);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
